// File: rtl/pid_sched.sv
// pid_sched: N-channel incremental PID controller sharing one multiply-accumulate datapath via round-robin arbitration.
// Define PID_SATURATE_EN to clamp results to the W-bit signed range; otherwise results wrap.
module pid_sched #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int K1 = 107,
    parameter int K2 = 104,
    parameter int K3 = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           req_valid,
    input  logic [N*W-1:0]         req_err,
    output logic [N-1:0]           req_ready,
    input  logic [N-1:0]           clr_ch,
    output logic                   out_valid,
    output logic [$clog2(N)-1:0]   out_ch,
    output logic signed [W-1:0]    out_u,
    output logic                   busy
);
    localparam int CW = $clog2(N);
    localparam int AW = 2 * W + 4;
    localparam logic signed [AW-1:0] UMAX = AW'((1 <<< (W - 1)) - 1);
    localparam logic signed [AW-1:0] UMIN = AW'(-(1 <<< (W - 1)));

    typedef enum logic [2:0] {IDLE, MAC1, MAC2, MAC3, WB} state_t;

    state_t                r_state, w_state_next;
    logic [CW-1:0]         r_ptr, r_ch, r_out_ch, w_win;
    logic signed [W-1:0]   r_e, r_out_u, w_err, w_res;
    logic signed [W-1:0]   r_u_prev [N];
    logic signed [W-1:0]   r_e1 [N];
    logic signed [W-1:0]   r_e2 [N];
    logic signed [AW-1:0]  r_acc, w_k, w_x, w_u, w_prod, w_acc_next;
    logic                  r_out_valid, w_found, w_accept;

    // Round-robin search upward from r_ptr, wrapping N-1 -> 0
    always_comb begin
        int idx;
        idx = 0;
        w_found = 1'b0;
        w_win = '0;
        w_err = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(r_ptr) + k) % N;
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_win = CW'(idx);
                w_err = req_err[idx*W +: W];
            end
        end
    end

    assign req_ready = (!reset && r_state == IDLE && w_found) ? N'(1) << w_win : '0;
    assign w_accept  = |(req_valid & req_ready);
    assign busy      = !reset && r_state != IDLE;

    always_comb begin
        w_state_next = r_state == IDLE ? (w_accept ? MAC1 : IDLE) :
                       r_state == MAC1 ? MAC2 :
                       r_state == MAC2 ? MAC3 :
                       r_state == MAC3 ? WB : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_state_next;
    end

    always_comb begin
        w_k = r_state == MAC1 ? AW'(K1) : r_state == MAC2 ? AW'(K2) : AW'(K3);
        w_x = r_state == MAC1 ? r_e : r_state == MAC2 ? r_e1[r_ch] : r_e2[r_ch];
        w_u = r_u_prev[r_ch];
        w_prod = w_k * w_x;
        w_acc_next = r_state == MAC1 ? w_u + w_prod :
                     r_state == MAC2 ? r_acc - w_prod : r_acc + w_prod;
    end

`ifdef PID_SATURATE_EN
    assign w_res = w_acc_next > UMAX ? UMAX[W-1:0] :
                   w_acc_next < UMIN ? UMIN[W-1:0] : w_acc_next[W-1:0];
`else
    assign w_res = w_acc_next[W-1:0];
`endif

    // The result is registered at the end of MAC3 so it is presented during WB
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
            r_ch <= '0;
            r_e <= '0;
            r_acc <= '0;
            r_out_valid <= 1'b0;
            r_out_u <= '0;
            r_out_ch <= '0;
            for (int i = 0; i < N; i++) begin
                r_u_prev[i] <= '0;
                r_e1[i] <= '0;
                r_e2[i] <= '0;
            end
        end else begin
            r_out_valid <= r_state == MAC3;
            if (w_accept) begin
                r_ch <= w_win;
                r_e <= w_err;
                r_ptr <= w_win == CW'(N - 1) ? '0 : CW'(w_win + 1'b1);
            end
            if (r_state == MAC1 || r_state == MAC2 || r_state == MAC3) r_acc <= w_acc_next;
            if (r_state == MAC3) begin
                r_out_u <= w_res;
                r_out_ch <= r_ch;
            end
            for (int i = 0; i < N; i++) begin
                if (clr_ch[i]) begin
                    r_u_prev[i] <= '0;
                    r_e1[i] <= '0;
                    r_e2[i] <= '0;
                end else if (r_state == WB && r_ch == CW'(i)) begin
                    r_e2[i] <= r_e1[i];
                    r_e1[i] <= r_e;
                    r_u_prev[i] <= r_out_u;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_u     = r_out_u;
    assign out_ch    = r_out_ch;
endmodule

// File: tb/tb_pid_sched.sv
// tb_pid_sched: directed scoreboard bench for pid_sched (W=8, N=4, default gains).
module tb_pid_sched;
    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        req_valid, req_ready, clr_ch;
    logic [31:0]       req_err;
    logic              out_valid, busy;
    logic [1:0]        out_ch;
    logic signed [7:0] out_u;

    typedef struct {int ch; int u; int cyc;} exp_t;
    exp_t q[$];
    int   tests = 0, fails = 0, cyc = 0;

`ifdef PID_SATURATE_EN
    localparam int EXP27 = 127;
`else
    localparam int EXP27 = -42;
`endif

    pid_sched dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_err(req_err),
        .req_ready(req_ready), .clr_ch(clr_ch), .out_valid(out_valid),
        .out_ch(out_ch), .out_u(out_u), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every result strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) check("unexpected out_valid", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                check("out_ch", int'(out_ch), e.ch);
                check("out_u", int'(out_u), e.u);
                check("out latency", cyc, e.cyc);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        clr_ch = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Called at a negedge; holds the request until granted, then waits out the operation
    task automatic send(input int ch, input logic signed [7:0] e, input int exp, input bit clr_wb);
        int t;
        t = 0;
        req_err[ch*8 +: 8] = e;
        req_valid[ch] = 1'b1;
        #1;
        while (!req_ready[ch] && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!req_ready[ch]) begin
            check("grant timeout", 0, 1);
            req_valid[ch] = 1'b0;
            return;
        end
        q.push_back('{ch, exp, cyc + 4});
        @(negedge clk);
        req_valid[ch] = 1'b0;
        repeat (3) @(negedge clk);
        if (clr_wb) clr_ch[ch] = 1'b1;
        @(negedge clk);
        clr_ch = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt, last;
        logic signed [7:0] ev [4];
        int xv [4];
        reset = 1'b1;
        req_valid = 4'hf;
        req_err = '0;
        clr_ch = '0;
        @(negedge clk);
        #1;
        check("reset req_ready", int'(req_ready), 0);
        check("reset busy", int'(busy), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_u", int'(out_u), 0);
        check("reset out_ch", int'(out_ch), 0);
        do_reset();

        send(0, 1, 107, 0);
        send(0, 1, 110, 0);
        send(0, 1, 115, 0);

        do_reset();
        send(1, 2, EXP27, 0);

        // All four channels requesting at once
        do_reset();
        ev = '{8'sd1, 8'sd0, -8'sd1, 8'sd1};
        xv = '{107, 0, -107, 107};
        for (int i = 0; i < 4; i++) req_err[i*8 +: 8] = ev[i];
        req_valid = 4'hf;
        nxt = 0;
        last = 0;
        for (int t = 0; t < 40 && nxt < 4; t++) begin
            #1;
            if (req_ready != 0) begin
                check("rr grant", int'(req_ready), 1 << nxt);
                if (nxt > 0) check("rr spacing", cyc - last, 5);
                last = cyc;
                q.push_back('{nxt, xv[nxt], cyc + 4});
                @(negedge clk);
                #1;
                check("rr pulse", int'(req_ready), 0);
                req_valid[nxt] = 1'b0;
                nxt++;
            end else @(negedge clk);
        end
        check("rr grants seen", nxt, 4);
        req_valid = '0;
        repeat (6) @(negedge clk);

        // Clearing ch2 leaves ch3 history intact
        do_reset();
        send(2, 1, 107, 0);
        send(3, 1, 107, 0);
        clr_ch[2] = 1'b1;
        @(negedge clk);
        clr_ch = '0;
        send(2, 1, 107, 0);
        send(3, 1, 110, 0);

        // Reset during MAC2 aborts the computation
        do_reset();
        req_err[7:0] = 8'sd5;
        req_valid[0] = 1'b1;
        #1;
        check("abort grant", int'(req_ready), 1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("abort busy", int'(busy), 0);
        check("abort out_valid", int'(out_valid), 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        send(0, 1, 107, 0);

        // Clear landing in the WB cycle of the same channel
        do_reset();
        send(0, 1, 107, 1);
        send(0, 1, 107, 0);

        for (int t = 0; t < 10 && q.size() != 0; t++) @(negedge clk);
        check("scoreboard drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pid_sched.md
PID_SCHED -- requirements
Module: pid_sched

Interface
REQ-001 SHALL have parameter W, default 8, meaning the signed data width of errors and outputs.
REQ-002 SHALL have parameter N, default 4, meaning the number of control channels (wheels) sharing one PID datapath.
REQ-003 SHALL have parameters K1, K2, K3, defaults 107, 104, 2, meaning the signed difference-equation gains.
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  N  per-channel error-sample valid.
REQ-007 SHALL have port req_err  input  N*W  per-channel signed error; channel i is in bits [i*W +: W].
REQ-008 SHALL have port req_ready  output  N  one-hot grant; a sample is accepted when req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port clr_ch  input  N  per-channel history clear.
REQ-010 SHALL have port out_valid  output  1  single-cycle result strobe.
REQ-011 SHALL have port out_ch  output  clog2(N)  channel index of the result.
REQ-012 SHALL have port out_u  output  W  signed control output.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL keep per-channel registers u_prev, e1 and e2 (each W-bit signed), plus one shared multiplier and a 2W+4-bit signed accumulator.
REQ-015 SHALL implement the FSM IDLE->MAC1->MAC2->MAC3->WB->IDLE: IDLE advances only on acceptance; every other state advances unconditionally.
REQ-016 SHALL, in IDLE, assert req_ready only for the round-robin winner: the first channel with req_valid set, searching upward from ptr with wrap N-1->0; req_ready SHALL be all-zero in every other state and when no request is valid.
REQ-017 SHALL, on acceptance, latch the channel index and its error e, and set ptr to the granted index + 1 (mod N).
REQ-018 SHALL perform the MAC steps as follows, sign-extended at full accumulator width:
- MAC1: acc = u_prev[ch] + K1*e
- MAC2: acc = acc - K2*e1[ch]
- MAC3: acc = acc + K3*e2[ch]
REQ-019 SHALL, in WB, assert out_valid for exactly one cycle with out_ch = ch and out_u = result, and update e2[ch] <= e1[ch], e1[ch] <= e, u_prev[ch] <= out_u.
REQ-020 SHALL have a latency of acceptance cycle T -> out_valid at T+4, with the earliest next acceptance at T+5.
REQ-021 SHALL hold out_u and out_ch at their last values when out_valid is low.
REQ-022 SHALL zero u_prev, e1 and e2 of every channel whose clr_ch bit is high, in any state; if the cleared channel is in WB in the same cycle, the clear SHALL win over the writeback, while out_valid/out_u SHALL still present the computed result.
REQ-023 SHALL, for a req_valid sample that is not granted, leave it pending with no loss; the requester holds req_valid and req_err stable until its grant.

Reset
REQ-024 SHALL, while reset is high (including mid-operation), force: state IDLE, ptr 0, all u_prev/e1/e2 0, acc 0, out_valid 0, out_u 0, out_ch 0, req_ready 0, busy 0; no result SHALL be emitted for an aborted computation.

Configuration
REQ-025 SHALL compile output saturation in or out with the macro PID_SATURATE_EN:
- defined: the WB result SHALL be clamped to [-2^(W-1), 2^(W-1)-1];
- undefined: the result SHALL be the low W bits of acc (two's-complement wrap).
- The clamped or wrapped value is both out_u and the stored u_prev.

Verification (W=8, N=4, default gains)
REQ-026 SHALL cover: after reset, ch0 e=1 three times -> out_u 107, 110, 115 with out_ch=0, each 4 cycles after acceptance.
REQ-027 SHALL cover: after reset, ch1 e=2 -> out_u 127 with PID_SATURATE_EN, -42 without.
REQ-028 SHALL cover: all four req_valid high from reset, held until grant -> grants in order 0,1,2,3, each req_ready a single-cycle pulse, 5 cycles apart.
REQ-029 SHALL cover: ch2 e=1 -> 107, then clr_ch[2] pulse, then e=1 -> 107 again; ch3 history unaffected.
REQ-030 SHALL cover: reset asserted during MAC2 -> no out_valid, busy 0 next cycle, next ch0 e=1 -> 107.
REQ-031 SHALL cover: clr_ch[0] in the WB cycle of ch0 -> out_u 107 emitted, then next e=1 -> 107.
